// File: rtl/stream_encoder_m.sv
// Transmit framer: valid/ready words -> SOF/addr/data/EOF[/CRC] byte symbols.
// Define STREAM_ENC_CRC_EN to append a CRC-16/CCITT-FALSE after EOF.
module stream_encoder_m #(
  parameter int          DW        = 32,
  parameter int          AW        = 8,
  parameter int          MAX_WORDS = 8,
  parameter logic [7:0]  IDLE_CHAR = 8'hBC,
  parameter logic [7:0]  SOF_CHAR  = 8'h5C,
  parameter logic [7:0]  EOF_CHAR  = 8'h3C
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tx_en,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic [7:0]    tx_data,
  output logic          tx_isk,
  output logic          frame_done,
  output logic          underrun
);
  localparam int BPW = DW / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WCW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_ADDR, S_DATA, S_EOF, S_CRCH, S_CRCL
  } state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  hold_q, shift_q;
  logic [7:0]     haddr_q;
  logic           hvalid_q, hlast_q, slast_q, urun_q;
  logic [BCW-1:0] bcnt_q;
  logic [WCW-1:0] wcnt_q, wcnt_inc;
  logic [7:0]     tx_data_q, sym_d;
  logic           tx_isk_q, isk_d;
  logic           done_q, done_d, urun_o_q, urun_d;
  logic           last_byte, close, in_data, drain, accept;

  assign s_ready    = ~hvalid_q;
  assign tx_data    = tx_data_q;
  assign tx_isk     = tx_isk_q;
  assign frame_done = done_q;
  assign underrun   = urun_o_q;

  assign accept    = s_valid & s_ready;
  assign last_byte = bcnt_q == BCW'(BPW - 1);
  assign wcnt_inc  = wcnt_q + 1'b1;
  assign close     = slast_q | (wcnt_inc == WCW'(MAX_WORDS));
  assign in_data   = tx_en & (state_q == S_DATA);
  // hold -> shift on the address symbol and between words of a frame
  assign drain = tx_en & ((state_q == S_ADDR) |
                 ((state_q == S_DATA) & last_byte & ~close & hvalid_q));

`ifdef STREAM_ENC_CRC_EN
  logic [15:0] crc_q, crc_d;

  function automatic logic [15:0] crc_upd(
    input logic [15:0] c,
    input logic [7:0]  b
  );
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (tx_en) begin
      if (state_q == S_IDLE && hvalid_q) crc_d = 16'hFFFF;
      else if (state_q == S_ADDR)        crc_d = crc_upd(crc_q, haddr_q);
      else if (state_q == S_DATA)        crc_d = crc_upd(crc_q, shift_q[DW-1 -: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= 16'hFFFF;
    else     crc_q <= crc_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tx_en) begin
      unique case (state_q)
        S_IDLE: if (hvalid_q) state_d = S_SOF;
        S_SOF:  state_d = S_ADDR;
        S_ADDR: state_d = S_DATA;
        S_DATA: if (last_byte && (close || !hvalid_q)) state_d = S_EOF;
`ifdef STREAM_ENC_CRC_EN
        S_EOF:  state_d = S_CRCH;
        S_CRCH: state_d = S_CRCL;
`else
        S_EOF:  state_d = S_IDLE;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sym_d  = tx_data_q;
    isk_d  = tx_isk_q;
    done_d = 1'b0;
    urun_d = 1'b0;
    if (tx_en) begin
      unique case (state_q)
        S_SOF:  begin sym_d = SOF_CHAR; isk_d = 1'b1; end
        S_ADDR: begin sym_d = haddr_q;  isk_d = 1'b0; end
        S_DATA: begin sym_d = shift_q[DW-1 -: 8]; isk_d = 1'b0; end
        S_EOF: begin
          sym_d  = EOF_CHAR;
          isk_d  = 1'b1;
          urun_d = urun_q;
`ifndef STREAM_ENC_CRC_EN
          done_d = 1'b1;
`endif
        end
`ifdef STREAM_ENC_CRC_EN
        S_CRCH: begin sym_d = crc_q[15:8]; isk_d = 1'b0; end
        S_CRCL: begin sym_d = crc_q[7:0]; isk_d = 1'b0; done_d = 1'b1; end
`endif
        default: begin sym_d = IDLE_CHAR; isk_d = 1'b1; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q <= IDLE_CHAR;
      tx_isk_q  <= 1'b1;
      done_q    <= 1'b0;
      urun_o_q  <= 1'b0;
    end else begin
      tx_data_q <= sym_d;
      tx_isk_q  <= isk_d;
      done_q    <= done_d;
      urun_o_q  <= urun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q   <= '0;
      haddr_q  <= '0;
      hlast_q  <= 1'b0;
      hvalid_q <= 1'b0;
      shift_q  <= '0;
      slast_q  <= 1'b0;
      bcnt_q   <= '0;
      wcnt_q   <= '0;
      urun_q   <= 1'b0;
    end else begin
      if (accept) begin
        hold_q  <= s_data;
        haddr_q <= 8'(s_addr);
        hlast_q <= s_last;
      end
      hvalid_q <= (hvalid_q & ~drain) | accept;
      if (drain) begin
        shift_q <= hold_q;
        slast_q <= hlast_q;
        bcnt_q  <= '0;
      end else if (in_data) begin
        shift_q <= shift_q << 8;
        bcnt_q  <= last_byte ? '0 : bcnt_q + 1'b1;
      end
      if (tx_en && state_q == S_IDLE) wcnt_q <= '0;
      else if (in_data && last_byte)  wcnt_q <= wcnt_inc;
      if (in_data && last_byte) urun_q <= ~close & ~hvalid_q;
    end
  end
endmodule

// File: tb/tb_stream_encoder_m.sv
// Scoreboard bench for stream_encoder_m; honours STREAM_ENC_CRC_EN.
module tb_stream_encoder_m;
  logic        clk = 1'b0;
  logic        rst, tx_en, s_valid, s_ready, s_last;
  logic [7:0]  s_addr, tx_data;
  logic [31:0] s_data;
  logic        tx_isk, frame_done, underrun;

  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic       done;
    logic       ur;
  } sym_t;

  sym_t        exp_q[$];
  logic [31:0] wq[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          tog = 1'b0;
  bit          in_frame = 1'b0;
  logic [7:0]  prev_d = 8'hBC;
  logic        prev_k = 1'b1;
  logic        mon_en, mon_rst;
  sym_t        mon_e;
  bit          ok;

  stream_encoder_m dut (
    .clk(clk), .rst(rst), .tx_en(tx_en),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .s_data(s_data), .s_last(s_last),
    .tx_data(tx_data), .tx_isk(tx_isk),
    .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_b(input logic [15:0] c,
                                        input logic [7:0] b);
    c = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++)
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  task automatic push_sym(input logic [7:0] d, input logic k,
                          input logic done, input logic ur);
    exp_q.push_back('{d: d, k: k, done: done, ur: ur});
  endtask

  // expected frame built from the global word list wq
  task automatic push_frame(input logic [7:0] a, input logic ur);
    logic [15:0] c;
    logic [31:0] w;
    c = crc_b(16'hFFFF, a);
    push_sym(8'h5C, 1'b1, 1'b0, 1'b0);
    push_sym(a, 1'b0, 1'b0, 1'b0);
    foreach (wq[i]) begin
      w = wq[i];
      for (int b = 3; b >= 0; b--) begin
        push_sym(w[b*8 +: 8], 1'b0, 1'b0, 1'b0);
        c = crc_b(c, w[b*8 +: 8]);
      end
    end
`ifdef STREAM_ENC_CRC_EN
    push_sym(8'h3C, 1'b1, 1'b0, ur);
    push_sym(c[15:8], 1'b0, 1'b0, 1'b0);
    push_sym(c[7:0], 1'b0, 1'b1, 1'b0);
`else
    push_sym(8'h3C, 1'b1, 1'b1, ur);
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    tx_en = tog ? ~tx_en : 1'b1;
  endtask

  task automatic send(input logic [7:0] a, input logic [31:0] d,
                      input logic l);
    bit got;
    got = 1'b0;
    s_valid = 1'b1; s_addr = a; s_data = d; s_last = l;
    for (int n = 0; n < 400; n++) begin
      if (s_ready) begin got = 1'b1; break; end
      tick();
    end
    chk("handshake", {31'd0, got}, 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic drain_wait();
    for (int n = 0; n < 2000; n++) begin
      if (exp_q.size() == 0 && !in_frame) break;
      tick();
    end
    chk("drain", exp_q.size() + {31'd0, in_frame}, 32'd0);
    repeat (4) tick();
  endtask

  always @(posedge clk) begin
    mon_en  = tx_en;
    mon_rst = rst;
    #1;
    if (mon_rst) begin
      in_frame = 1'b0;
    end else if (!mon_en) begin
      chk("hold", {21'd0, tx_data, tx_isk, frame_done, underrun},
          {21'd0, prev_d, prev_k, 2'b00});
    end else begin
      if (!in_frame && tx_data === 8'h5C && tx_isk === 1'b1) begin
        chk("gap", {23'd0, prev_d, prev_k}, {23'd0, 8'hBC, 1'b1});
        in_frame = 1'b1;
      end
      if (in_frame) begin
        chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("sym", {21'd0, tx_data, tx_isk, frame_done, underrun},
              {21'd0, mon_e});
          if (mon_e.done) in_frame = 1'b0;
        end else begin
          in_frame = 1'b0;
        end
      end else begin
        chk("idle", {21'd0, tx_data, tx_isk, frame_done, underrun},
            {21'd0, 8'hBC, 1'b1, 2'b00});
      end
    end
    prev_d = tx_data;
    prev_k = tx_isk;
  end

  initial begin
    rst = 1'b1; tx_en = 1'b0; s_valid = 1'b0;
    s_addr = '0; s_data = '0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", {24'd0, tx_data}, 32'h0000_00BC);
    chk("rst_flags", {28'd0, tx_isk, s_ready, frame_done, underrun},
        32'b1100);
    rst = 1'b0;
    tick();
    repeat (3) tick();

    // 1: two-word frame, tx_en constant
    push_sym(8'h5C, 1'b1, 1'b0, 1'b0);
    for (int i = 8'h31; i <= 8'h39; i++)
      push_sym(8'(i), 1'b0, 1'b0, 1'b0);
`ifdef STREAM_ENC_CRC_EN
    push_sym(8'h3C, 1'b1, 1'b0, 1'b0);
    push_sym(8'h29, 1'b0, 1'b0, 1'b0);
    push_sym(8'hB1, 1'b0, 1'b1, 1'b0);
`else
    push_sym(8'h3C, 1'b1, 1'b1, 1'b0);
`endif
    send(8'h31, 32'h3233_3435, 1'b0);
    send(8'hEE, 32'h3637_3839, 1'b1);
    drain_wait();

    // 2: same frame, tx_en toggling
    tog = 1'b1;
    wq = '{32'h3233_3435, 32'h3637_3839};
    push_frame(8'h31, 1'b0);
    send(8'h31, 32'h3233_3435, 1'b0);
    send(8'hEE, 32'h3637_3839, 1'b1);
    drain_wait();
    tog = 1'b0;
    tick();

    // 3: ten-word burst splits at MAX_WORDS
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back(32'hA000_0000 + i * 32'h0101_0101);
    push_frame(8'h04, 1'b0);
    wq.delete();
    for (int i = 8; i < 10; i++) wq.push_back(32'hA000_0000 + i * 32'h0101_0101);
    push_frame(8'h48, 1'b0);
    for (int i = 0; i < 10; i++)
      send(i == 0 ? 8'h04 : 8'(8'h40 + i),
           32'hA000_0000 + i * 32'h0101_0101, i == 9);
    drain_wait();

    // 4: underrun after one non-last word
    wq = '{32'hDEAD_BEEF};
    push_frame(8'h21, 1'b1);
    send(8'h21, 32'hDEAD_BEEF, 1'b0);
    drain_wait();

    // 5: data bytes equal to K codes
    wq = '{32'h5CBC_3C00};
    push_frame(8'h55, 1'b0);
    send(8'h55, 32'h5CBC_3C00, 1'b1);
    drain_wait();

    // 6: reset during DATA with a word held
    wq = '{32'h1122_3344, 32'h5566_7788};
    push_frame(8'h77, 1'b0);
    send(8'h77, 32'h1122_3344, 1'b0);
    send(8'h78, 32'h5566_7788, 1'b1);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (tx_data inside {8'h11, 8'h22, 8'h33}) begin ok = 1'b1; break; end
      tick();
    end
    chk("reach_data", {31'd0, ok}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_out", {23'd0, tx_data, tx_isk}, {23'd0, 8'hBC, 1'b1});
    chk("mid_rst_flags", {29'd0, s_ready, frame_done, underrun}, 32'b100);
    repeat (20) tick();
    drain_wait();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
